// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: latches two endpoints and a palette index, then issues one
// framebuffer write per pixel. Optional clipping via LINE_RASTERIZER_CLIP_EN.
module line_rasterizer #(
    parameter int unsigned RESOLUTION_X   = 400,
    parameter int unsigned RESOLUTION_Y   = 300,
    parameter int unsigned PALETTE_LENGTH = 256
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              start_i,
    input  logic [$clog2(RESOLUTION_X)-1:0]   x0_i,
    input  logic [$clog2(RESOLUTION_Y)-1:0]   y0_i,
    input  logic [$clog2(RESOLUTION_X)-1:0]   x1_i,
    input  logic [$clog2(RESOLUTION_Y)-1:0]   y1_i,
    input  logic [$clog2(PALETTE_LENGTH)-1:0] color_i,
    input  logic                              stall_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              we_o,
    output logic [$clog2(RESOLUTION_X)-1:0]   wr_pxl_x_o,
    output logic [$clog2(RESOLUTION_Y)-1:0]   wr_pxl_y_o,
    output logic [$clog2(PALETTE_LENGTH)-1:0] wr_palette_index_o
);

    localparam int unsigned XW = $clog2(RESOLUTION_X);
    localparam int unsigned YW = $clog2(RESOLUTION_Y);
    localparam int unsigned CW = $clog2(PALETTE_LENGTH);
    localparam int unsigned EW = ((XW > YW) ? XW : YW) + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d, x1_q, x1_d;
    logic [YW-1:0]         y_q, y_d, y1_q, y1_d;
    logic [CW-1:0]         color_q, color_d;
    logic signed [EW-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                  sx_q, sx_d, sy_q, sy_d;
    logic                  busy_q, busy_d, done_q, done_d;

    logic [EW-1:0]         x_ext, x1_ext, y_ext, y1_ext;
    logic [EW-1:0]         dx_abs, dy_abs;
    logic signed [EW-1:0]  e2;
    logic                  step_x, step_y;
    logic                  at_end;

    // Zero-extended endpoints and magnitudes used during SETUP
    always_comb begin
        x_ext  = EW'(x_q);
        x1_ext = EW'(x1_q);
        y_ext  = EW'(y_q);
        y1_ext = EW'(y1_q);
        dx_abs = (x1_q >= x_q) ? (x1_ext - x_ext) : (x_ext - x1_ext);
        dy_abs = (y1_q >= y_q) ? (y1_ext - y_ext) : (y_ext - y1_ext);
        e2     = err_q <<< 1;
        step_x = (e2 >= dy_q);
        step_y = (e2 <= dx_q);
        at_end = (x_q == x1_q) && (y_q == y1_q);
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        color_d = color_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        sx_d    = sx_q;
        sy_d    = sy_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SETUP;
                    x_d     = x0_i;
                    y_d     = y0_i;
                    x1_d    = x1_i;
                    y1_d    = y1_i;
                    color_d = color_i;
                end
            end
            SETUP: begin
                dx_d    = $signed(dx_abs);
                dy_d    = $signed(EW'(0) - dy_abs);
                err_d   = $signed(dx_abs - dy_abs);
                sx_d    = (x1_q < x_q);
                sy_d    = (y1_q < y_q);
                state_d = DRAW;
            end
            DRAW: begin
                if (!stall_i) begin
                    if (at_end) begin
                        state_d = DONE;
                    end else begin
                        err_d = err_q + (step_x ? dy_q : EW'(0)) + (step_y ? dx_q : EW'(0));
                        if (step_x) x_d = sx_q ? (x_q - XW'(1)) : (x_q + XW'(1));
                        if (step_y) y_d = sy_q ? (y_q - YW'(1)) : (y_q + YW'(1));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SETUP) || (state_d == DRAW);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef LINE_RASTERIZER_CLIP_EN
    localparam logic [XW:0] RES_X = (XW+1)'(RESOLUTION_X);
    localparam logic [YW:0] RES_Y = (YW+1)'(RESOLUTION_Y);
    logic in_range;
    assign in_range = ({1'b0, x_q} < RES_X) && ({1'b0, y_q} < RES_Y);
    // Off-screen pixels are still stepped through, only their strobe is suppressed
    assign we_o = (state_q == DRAW) && !stall_i && in_range;
`else
    assign we_o = (state_q == DRAW) && !stall_i;
`endif

    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign wr_pxl_x_o         = x_q;
    assign wr_pxl_y_o         = y_q;
    assign wr_palette_index_o = color_q;

endmodule
